param_updown_counter: RTL

Parametrised up/down counter that generalises the team's fixed 3-bit up counter. It adds configurable width and modulus, runtime direction, count enable, synchronous clear and load, a wrap-or-saturate mode, and status outputs (terminal count, wrap pulse, sticky overflow). It is intended as the common counting primitive for timers, address generators and event tallies in the design.

---
 rtl/param_updown_counter.sv | 76 +++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap-or-saturate limits, sync clear/load,
// terminal-count look-ahead, one-cycle wrap pulse and sticky overflow flag.
module param_updown_counter #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic             at_max;
    logic             at_zero;
    logic             at_limit;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;

    assign at_max   = (count == CNT_MAX);
    assign at_zero  = (count == CNT_ZERO);
    assign at_limit = up_dn ? at_max : at_zero;

    // Look-ahead only: clr and load deliberately do not mask tc.
    assign tc = reset & en & at_limit;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf;
        if (clr) begin
            count_nxt = CNT_ZERO;
            ovf_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = (load_val > CNT_MAX) ? CNT_MAX : load_val;
        end else if (en) begin
            if (at_limit) begin
                ovf_nxt = 1'b1;
                // Wrap jumps straight to the opposite limit, skipping unused codes.
                if (!SATURATE) begin
                    count_nxt = up_dn ? CNT_ZERO : CNT_MAX;
                    wrap_nxt  = 1'b1;
                end
            end else if (up_dn) begin
                count_nxt = count + CNT_ONE;
            end else begin
                count_nxt = count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= CNT_ZERO;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule
